master_cmd_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the command side of `custom_master_slave`. It accepts read/write requests from two on-chip clients, grants one at a time, and drives the master's `rdwr_cntl`/`n_action`/`add_data_sel`/`rdwr_address` inputs in the fixed setup→start→wait order. It then waits for the master's completion pulse and returns a per-client done pulse. A watchdog counter bounds every transfer.

---
 rtl/master_cmd_arbiter.sv | 125 ++++++++++++
 tb/tb_master_cmd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_cmd_arbiter.sv
// Two-client round-robin arbiter that sequences one master command at a time
// (setup -> start strobe -> wait for completion) with a watchdog on every transfer.
`timescale 1ns/1ps
module master_cmd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              req0_done,
  output logic              req1_done,
  input  logic              master_done,
  output logic              rdwr_cntl,
  output logic              n_action,
  output logic              add_data_sel,
  output logic [ADDR_W-1:0] rdwr_address,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  // Last WAIT count before the watchdog forces completion.
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic        gnt;
  logic        last_grant;
  logic        timeout_flag;
  logic        pick;
  logic [9:0]  wd_cnt;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    pick = req1_valid;
    if (req0_valid && req1_valid) pick = ~last_grant;
  end

  assign busy        = (state != S_IDLE);
  assign timeout_err = timeout_flag;

  // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      gnt          <= 1'b0;
      last_grant   <= 1'b1;
      timeout_flag <= 1'b0;
      wd_cnt       <= '0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      rdwr_cntl    <= 1'b0;
      n_action     <= 1'b1;
      add_data_sel <= 1'b0;
      rdwr_address <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt          <= pick;
            rdwr_cntl    <= pick ? req1_write : req0_write;
            rdwr_address <= pick ? req1_address : req0_address;
            add_data_sel <= 1'b1;
            n_action     <= 1'b1;
            req0_ready   <= ~pick;
            req1_ready   <= pick;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          n_action     <= 1'b0;
          add_data_sel <= 1'b0;
          state        <= S_START;
        end
        S_START: begin
          n_action <= 1'b1;
          wd_cnt   <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A real completion beats a watchdog expiry in the same cycle.
          if (master_done) begin
            req0_done <= ~gnt;
            req1_done <= gnt;
            state     <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            req0_done    <= ~gnt;
            req1_done    <= gnt;
            timeout_flag <= 1'b1;
            state        <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
          end
        end
        S_DONE: begin
          last_grant   <= gnt;
          timeout_flag <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_cmd_arbiter.sv
// Randomized bench for master_cmd_arbiter: a transaction-level model predicts grants,
// strobes and completions; a monitor pops those predictions whenever the DUT responds.
`timescale 1ns/1ps
module tb_master_cmd_arbiter;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int RUN_END = 2000;

  typedef struct {
    int               cyc;
    logic             cli;
    logic             wr;
    logic [ADDR_W-1:0] addr;
    logic             to;
  } exp_t;

  logic                   tb_clk = 1'b0;
  logic                   reset_n;
  logic [1:0]             v;
  logic [1:0]             w;
  logic [1:0][ADDR_W-1:0] addr;
  logic                   master_done;
  logic                   req0_ready, req1_ready, req0_done, req1_done;
  logic                   rdwr_cntl, n_action, add_data_sel, busy, timeout_err;
  logic [ADDR_W-1:0]      rdwr_address;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   stop = 1'b0;
  exp_t rdy_q[$];
  exp_t start_q[$];
  exp_t done_q[$];

  master_cmd_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (tb_clk),
    .reset_n      (reset_n),
    .req0_valid   (v[0]),
    .req0_write   (w[0]),
    .req0_address (addr[0]),
    .req1_valid   (v[1]),
    .req1_write   (w[1]),
    .req1_address (addr[1]),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_done    (req0_done),
    .req1_done    (req1_done),
    .master_done  (master_done),
    .rdwr_cntl    (rdwr_cntl),
    .n_action     (n_action),
    .add_data_sel (add_data_sel),
    .rdwr_address (rdwr_address),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 1) ? req1_ready : req0_ready;
  endfunction

  // Model plus monitor, evaluated once per cycle at the falling edge.
  task automatic monitor();
    bit   in_xfer = 1'b0;
    bit   last = 1'b1;
    int   next_free = 0;
    int   wait_start = 0;
    exp_t cur;
    exp_t e;
    while (!stop) begin
      @(negedge tb_clk);
      if (!reset_n) begin
        check("rst_n_action", n_action, 1);
        check("rst_outputs", {req0_ready, req1_ready, req0_done, req1_done,
                              rdwr_cntl, add_data_sel, busy, timeout_err}, 0);
        check("rst_address", rdwr_address, 0);
        rdy_q.delete();
        start_q.delete();
        done_q.delete();
        in_xfer   = 1'b0;
        last      = 1'b1;
        next_free = cyc + 1;
        continue;
      end
      if (rdy_q.size() > 0 && rdy_q[0].cyc < cyc) begin
        e = rdy_q.pop_front();
        check("ready_missed", cyc, e.cyc);
      end
      if (start_q.size() > 0 && start_q[0].cyc < cyc) begin
        e = start_q.pop_front();
        check("strobe_missed", cyc, e.cyc);
      end
      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        e = done_q.pop_front();
        check("done_missed", cyc, e.cyc);
      end
      if (req0_ready || req1_ready) begin
        if (rdy_q.size() == 0) check("ready_spurious", {req1_ready, req0_ready}, 0);
        else begin
          e = rdy_q.pop_front();
          check("ready_cycle", cyc, e.cyc);
          check("ready_who", {req1_ready, req0_ready}, e.cli ? 2 : 1);
          check("setup_addr", rdwr_address, e.addr);
          check("setup_cntl", rdwr_cntl, e.wr);
          check("setup_ads", {add_data_sel, n_action, busy}, 3'b111);
        end
      end
      if (!n_action) begin
        if (start_q.size() == 0) check("strobe_spurious", n_action, 1);
        else begin
          e = start_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_addr", rdwr_address, e.addr);
          check("strobe_cntl", rdwr_cntl, e.wr);
          check("strobe_ads", add_data_sel, 0);
        end
      end
      if (req0_done || req1_done) begin
        if (done_q.size() == 0) check("done_spurious", {req1_done, req0_done}, 0);
        else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_who", {req1_done, req0_done}, e.cli ? 2 : 1);
          check("done_timeout_err", timeout_err, e.to);
        end
      end else if (timeout_err) begin
        check("timeout_err_alone", timeout_err, 0);
      end
      // Predict from the inputs the DUT will sample at the coming rising edge.
      if (in_xfer && cyc >= wait_start) begin
        if (master_done || (cyc - wait_start == TIMEOUT - 1)) begin
          cur.cyc = cyc + 1;
          cur.to  = !master_done;
          done_q.push_back(cur);
          last      = cur.cli;
          in_xfer   = 1'b0;
          next_free = cyc + 2;
        end
      end else if (!in_xfer && cyc >= next_free && (v[0] || v[1])) begin
        cur.cli  = (v[0] && v[1]) ? !last : v[1];
        cur.wr   = w[cur.cli];
        cur.addr = addr[cur.cli];
        cur.to   = 1'b0;
        cur.cyc  = cyc + 1;
        rdy_q.push_back(cur);
        cur.cyc  = cyc + 2;
        start_q.push_back(cur);
        wait_start = cyc + 3;
        in_xfer    = 1'b1;
      end
    end
  endtask

  task automatic wait_ready(input int i);
    for (int t = 0; t < 200; t++) begin
      @(negedge tb_clk);
      if (rdy(i)) break;
    end
    check((i == 1) ? "req1_ready_wait" : "req0_ready_wait", rdy(i), 1);
  endtask

  task automatic wait_strobe();
    for (int t = 0; t < 50; t++) begin
      @(negedge tb_clk);
      if (!n_action) break;
    end
    check("strobe_wait", n_action, 0);
  endtask

  task automatic client(input int i);
    while (cyc < RUN_END) begin
      if (!v[i]) begin
        repeat ($urandom_range(0, 4)) @(posedge tb_clk);
        #1;
        v[i]    = 1'b1;
        w[i]    = 1'($urandom);
        addr[i] = $urandom;
      end
      wait_ready(i);
      @(posedge tb_clk);
      #1;
      if ($urandom_range(0, 2) == 0) begin
        w[i]    = 1'($urandom);
        addr[i] = $urandom;
      end else begin
        v[i] = 1'b0;
      end
    end
    if (v[i]) begin
      wait_ready(i);
      @(posedge tb_clk);
      #1;
      v[i] = 1'b0;
    end
  endtask

  // Master model: a scheduled completion per strobe plus random stray pulses.
  task automatic responder();
    int sched = -1;
    while (cyc < RUN_END + 100) begin
      @(negedge tb_clk);
      if (!n_action) begin
        case ($urandom_range(0, 3))
          0:       sched = cyc + 1;
          1:       sched = cyc + TIMEOUT;
          2:       sched = cyc + 1 + int'($urandom_range(0, TIMEOUT + 2));
          default: sched = -1;
        endcase
      end
      @(posedge tb_clk);
      #1;
      master_done = (cyc == sched) || ($urandom_range(0, 15) == 0);
    end
    master_done = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (rdy_q.size() == 0 && start_q.size() == 0 && done_q.size() == 0) break;
      @(negedge tb_clk);
    end
    check("drain_pending", rdy_q.size() + start_q.size() + done_q.size(), 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    v           = '0;
    w           = '0;
    addr        = '0;
    master_done = 1'b0;
    fork
      monitor();
      begin
        repeat (3) @(posedge tb_clk);
        #1;
        // Contention right after reset: req0 writes 0x248, req1 reads 0x16.
        reset_n = 1'b1;
        addr[0] = 32'h248;
        addr[1] = 32'h16;
        w       = 2'b01;
        v       = 2'b11;
        fork
          client(0);
          client(1);
          responder();
        join
        drain();

        // Reset in the middle of WAIT aborts the transfer without a done pulse.
        @(posedge tb_clk);
        #1;
        v[1]    = 1'b1;
        w[1]    = 1'b1;
        addr[1] = 32'hABCD;
        wait_strobe();
        @(posedge tb_clk);
        #1;
        v[1] = 1'b0;
        @(posedge tb_clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        reset_n = 1'b1;
        v[1]    = 1'b1;
        w[1]    = 1'b0;
        addr[1] = 32'h16;
        wait_ready(1);
        @(posedge tb_clk);
        #1;
        v[1] = 1'b0;
        wait_strobe();
        @(posedge tb_clk);
        #1;
        master_done = 1'b1;
        @(posedge tb_clk);
        #1;
        master_done = 1'b0;
        drain();
        repeat (3) @(posedge tb_clk);
        stop = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
